// File: rtl/srp16_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// srp16_boot_loader_pkg
// Shared definitions for the SRP16 boot loader: the loader state encoding
// (3-bit), the default frame parameters and the checksum helper. The
// testbench imports this package so that it uses the same MAGIC default.
// ---------------------------------------------------------------------------
package srp16_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } boot_state_e;

    localparam logic [7:0]  DEFAULT_MAGIC          = 8'h5A;
    localparam logic [15:0] DEFAULT_BASE_ADDR      = 16'h0000;
    localparam logic [15:0] DEFAULT_MAX_LEN        = 16'h8000;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 100000;

    // A frame is good when the modulo-256 sum of payload and CHK is zero.
    function automatic logic checksum_ok(input logic [7:0] sum, input logic [7:0] chk);
        logic [7:0] total;
        total = sum + chk;
        return (total == 8'h00);
    endfunction

    // States in which a frame is in flight and the idle timer runs.
    function automatic logic frame_active(input boot_state_e st);
        return (st == ST_LEN_HI) || (st == ST_LEN_LO) ||
               (st == ST_PAYLOAD) || (st == ST_CHECK);
    endfunction

endpackage

// File: rtl/srp16_boot_loader_timeout.sv
// ---------------------------------------------------------------------------
// boot_timeout_counter
// Counts idle cycles while a frame is in flight. The count restarts whenever
// 'clear' is high; 'expired' flags the cycle in which the count has reached
// TIMEOUT_CYCLES-1 while enabled.
//  clk      in  system clock
//  reset    in  asynchronous active-low reset
//  clear    in  restart the count (byte accepted, or no frame in flight)
//  enable   in  count this cycle
//  expired  out idle limit reached
// ---------------------------------------------------------------------------
module boot_timeout_counter
    import srp16_boot_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] ONE  = TW'(1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    assign expired = enable && (timer_q == LAST);

    // Next timer value: clear wins, and the count stops at the limit.
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (enable && !expired) begin
            timer_d = timer_q + ONE;
        end else begin
            timer_d = timer_q;
        end
    end

    // Timer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/srp16_boot_loader.sv
// ---------------------------------------------------------------------------
// srp16_boot_loader
// Receives a framed program image (MAGIC, LEN_HI, LEN_LO, payload, CHK) on a
// byte stream, writes the payload into byte-wide program memory starting at
// BASE_ADDR and releases the SRP16 from reset once the checksum matches.
// Memory is written only while cpu_reset is high.
//  clk         in   system clock, rising edge
//  reset       in   asynchronous active-low reset
//  rx_data     in   stream byte
//  rx_valid    in   rx_data valid
//  rx_ready    out  loader accepts a byte (transfer on rx_valid & rx_ready)
//  start       in   re-arm pulse, honoured in DONE / ERROR only
//  mem_addr    out  memory write address
//  mem_wdata   out  memory write data
//  mem_write   out  one-cycle write strobe per payload byte
//  cpu_reset   out  active-high processor reset
//  boot_done   out  image loaded, checksum good
//  boot_error  out  frame rejected
// ---------------------------------------------------------------------------
module srp16_boot_loader
    import srp16_boot_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter logic [7:0]  MAGIC          = DEFAULT_MAGIC,
    parameter logic [15:0] MAX_LEN        = DEFAULT_MAX_LEN,
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        start,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_write,
    output logic        cpu_reset,
    output logic        boot_done,
    output logic        boot_error
);

    boot_state_e state_q, state_d;

    logic [15:0] len_q,       len_d;
    logic [15:0] count_q,     count_d;
    logic [7:0]  sum_q,       sum_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_write_q, mem_write_d;
    logic        rx_ready_q,  rx_ready_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        boot_done_q, boot_done_d;
    logic        boot_error_q, boot_error_d;

    logic        accept_s;
    logic        active_s;
    logic        tmo_expired_s;
    logic [15:0] len_full_s;
    logic [15:0] count_inc_s;

    assign accept_s    = rx_valid && rx_ready_q;
    assign active_s    = frame_active(state_q);
    assign len_full_s  = {len_q[15:8], rx_data};
    assign count_inc_s = count_q + 16'd1;

    // An accepted byte restarts the idle count; outside a frame it is held at zero.
    boot_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept_s || !active_s),
        .enable  (active_s),
        .expired (tmo_expired_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= 16'h0000;
            count_q      <= 16'h0000;
            sum_q        <= 8'h00;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= 8'h00;
            mem_write_q  <= 1'b0;
            rx_ready_q   <= 1'b1;
            cpu_reset_q  <= 1'b1;
            boot_done_q  <= 1'b0;
            boot_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_write_q  <= mem_write_d;
            rx_ready_q   <= rx_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            boot_done_q  <= boot_done_d;
            boot_error_q <= boot_error_d;
        end
    end

    // Next-state logic. An accepted byte takes priority over the idle limit,
    // so a byte arriving in the last allowed cycle still counts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (rx_data == MAGIC)) begin
                    state_d = ST_LEN_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    state_d = ST_LEN_LO;
                end else if (tmo_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    if (len_full_s > MAX_LEN) begin
                        state_d = ST_ERROR;
                    end else if (len_full_s == 16'h0000) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_PAYLOAD: begin
                if (accept_s) begin
                    if (count_inc_s == len_q) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    if (checksum_ok(sum_q, rx_data)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else if (tmo_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            // Unused encodings park in ERROR so the processor stays in reset.
            default: state_d = ST_ERROR;
        endcase
    end

    // Datapath and output register inputs. Status outputs are registered
    // copies decoded from the next state, so they line up with state_q.
    always_comb begin
        len_d       = len_q;
        count_d     = count_q;
        sum_d       = sum_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (rx_data == MAGIC)) begin
                    len_d   = 16'h0000;
                    count_d = 16'h0000;
                    sum_d   = 8'h00;
                end else begin
                    len_d = len_q;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    len_d = {rx_data, 8'h00};
                end else begin
                    len_d = len_q;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_d   = len_full_s;
                    count_d = 16'h0000;
                end else begin
                    len_d = len_q;
                end
            end
            ST_PAYLOAD: begin
                if (accept_s) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = BASE_ADDR + count_q;  // wraps at 16 bits
                    mem_wdata_d = rx_data;
                    sum_d       = sum_q + rx_data;
                    count_d     = count_inc_s;
                end else begin
                    mem_write_d = 1'b0;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    sum_d   = 8'h00;
                    count_d = 16'h0000;
                end else begin
                    sum_d = sum_q;
                end
            end
            default: begin
                mem_write_d = 1'b0;
            end
        endcase

        rx_ready_d   = (state_d != ST_DONE) && (state_d != ST_ERROR);
        cpu_reset_d  = (state_d != ST_DONE);
        boot_done_d  = (state_d == ST_DONE);
        boot_error_d = (state_d == ST_ERROR);
    end

    assign rx_ready   = rx_ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_write  = mem_write_q;
    assign cpu_reset  = cpu_reset_q;
    assign boot_done  = boot_done_q;
    assign boot_error = boot_error_q;

endmodule

// File: tb/tb_srp16_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_srp16_boot_loader
// Two loaders share one input stream: one with BASE_ADDR 0000, one with
// BASE_ADDR FFFE (address wrap). Both use TIMEOUT_CYCLES 16. Expected
// results come from a byte-level frame parser kept in the bench.
// ---------------------------------------------------------------------------
module tb_srp16_boot_loader;
    import srp16_boot_loader_pkg::*;

    localparam int          TMO    = 16;
    localparam logic [15:0] BASE_A = 16'h0000;
    localparam logic [15:0] BASE_B = 16'hFFFE;
    localparam logic [15:0] MAXL   = 16'h8000;
    localparam logic [7:0]  MAGIC  = DEFAULT_MAGIC;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        start;

    logic        rx_ready_a, mem_write_a, cpu_reset_a, boot_done_a, boot_error_a;
    logic [15:0] mem_addr_a;
    logic [7:0]  mem_wdata_a;
    logic        rx_ready_b, mem_write_b, cpu_reset_b, boot_done_b, boot_error_b;
    logic [15:0] mem_addr_b;
    logic [7:0]  mem_wdata_b;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    logic [23:0] wq_a[$];
    logic [23:0] wq_b[$];
    logic [7:0]  stim_b[$];
    int          stim_g[$];
    logic [15:0] exp_off[$];
    logic [7:0]  exp_dat[$];
    int          exp_out;   // 0 idle, 1 done, 2 error

    always #5 clk = ~clk;

    srp16_boot_loader #(
        .BASE_ADDR (BASE_A), .MAGIC (MAGIC), .MAX_LEN (MAXL), .TIMEOUT_CYCLES (TMO)
    ) dut_a (
        .clk (clk), .reset (reset), .rx_data (rx_data), .rx_valid (rx_valid),
        .rx_ready (rx_ready_a), .start (start), .mem_addr (mem_addr_a),
        .mem_wdata (mem_wdata_a), .mem_write (mem_write_a), .cpu_reset (cpu_reset_a),
        .boot_done (boot_done_a), .boot_error (boot_error_a)
    );

    srp16_boot_loader #(
        .BASE_ADDR (BASE_B), .MAGIC (MAGIC), .MAX_LEN (MAXL), .TIMEOUT_CYCLES (TMO)
    ) dut_b (
        .clk (clk), .reset (reset), .rx_data (rx_data), .rx_valid (rx_valid),
        .rx_ready (rx_ready_b), .start (start), .mem_addr (mem_addr_b),
        .mem_wdata (mem_wdata_b), .mem_write (mem_write_b), .cpu_reset (cpu_reset_b),
        .boot_done (boot_done_b), .boot_error (boot_error_b)
    );

    // Record every write strobe and any write seen with the processor released.
    always @(negedge clk) begin
        if (mem_write_a) begin
            wq_a.push_back({mem_addr_a, mem_wdata_a});
            if (!cpu_reset_a) viol <= viol + 1;
        end
        if (mem_write_b) begin
            wq_b.push_back({mem_addr_b, mem_wdata_b});
            if (!cpu_reset_b) viol <= viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input int g);
        stim_b.push_back(b);
        stim_g.push_back(g);
    endtask

    function automatic int rgap();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 8) return int'($urandom_range(0, 2));
        return 14 + int'($urandom_range(0, 3));
    endfunction

    // Frame parser: which payload bytes land where and how the frame ends.
    // gap = idle cycles before a byte; once a frame has started a gap of
    // TMO or more rejects it. A frame still open at the end times out.
    task automatic model_run();
        int          phase;
        int          cnt;
        int          sum;
        logic [15:0] len;
        exp_off.delete();
        exp_dat.delete();
        exp_out = 0;
        phase = 0; cnt = 0; sum = 0; len = 16'h0000;
        for (int i = 0; i < stim_b.size(); i++) begin
            if (phase != 0 && stim_g[i] >= TMO) begin exp_out = 2; return; end
            case (phase)
                0: if (stim_b[i] == MAGIC) phase = 1;
                1: begin len[15:8] = stim_b[i]; phase = 2; end
                2: begin
                    len[7:0] = stim_b[i];
                    if (len > MAXL) begin exp_out = 2; return; end
                    phase = (len == 16'h0000) ? 4 : 3;
                end
                3: begin
                    exp_off.push_back(16'(cnt));
                    exp_dat.push_back(stim_b[i]);
                    sum = sum + int'(stim_b[i]);
                    cnt++;
                    if (cnt == int'(len)) phase = 4;
                end
                4: begin
                    exp_out = (((sum + int'(stim_b[i])) % 256) == 0) ? 1 : 2;
                    return;
                end
                default: ;
            endcase
        end
        if (phase != 0) exp_out = 2;
    endtask

    // Called at a negedge; returns at the negedge after the byte's cycle.
    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic play(input int from, input int upto);
        for (int i = from; i < upto; i++) send(stim_b[i], stim_g[i]);
    endtask

    task automatic begin_frame();
        model_run();
        wq_a.delete();
        wq_b.delete();
    endtask

    // Re-arm with a MAGIC byte offered in the same cycle (it must be dropped).
    task automatic pulse_start(input string tag);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = MAGIC;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        chk({tag, "_st_rdy_a"}, 32'(rx_ready_a),   32'd1);
        chk({tag, "_st_done_a"}, 32'(boot_done_a), 32'd0);
        chk({tag, "_st_err_a"}, 32'(boot_error_a), 32'd0);
        chk({tag, "_st_crst_b"}, 32'(cpu_reset_b), 32'd1);
    endtask

    task automatic settle_and_check(input string tag);
        logic [15:0] a;
        repeat (TMO + 4) @(negedge clk);
        chk({tag, "_done_a"}, 32'(boot_done_a),  32'(exp_out == 1));
        chk({tag, "_err_a"},  32'(boot_error_a), 32'(exp_out == 2));
        chk({tag, "_crst_a"}, 32'(cpu_reset_a),  32'(exp_out != 1));
        chk({tag, "_rdy_a"},  32'(rx_ready_a),   32'(exp_out == 0));
        chk({tag, "_done_b"}, 32'(boot_done_b),  32'(exp_out == 1));
        chk({tag, "_err_b"},  32'(boot_error_b), 32'(exp_out == 2));
        chk({tag, "_nwr_a"},  32'(wq_a.size()),  32'(exp_off.size()));
        chk({tag, "_nwr_b"},  32'(wq_b.size()),  32'(exp_off.size()));
        for (int i = 0; i < exp_off.size() && i < wq_a.size() && i < wq_b.size(); i++) begin
            a = BASE_A + exp_off[i];
            chk({tag, "_wr_a"}, {8'h00, wq_a[i]}, {8'h00, a, exp_dat[i]});
            a = BASE_B + exp_off[i];
            chk({tag, "_wr_b"}, {8'h00, wq_b[i]}, {8'h00, a, exp_dat[i]});
        end
        if (exp_out != 0) pulse_start(tag);
    endtask

    task automatic run_frame(input string tag);
        begin_frame();
        play(0, stim_b.size());
        settle_and_check(tag);
    endtask

    initial begin
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        start    = 1'b0;
        #7;
        chk("rst_crst",  32'(cpu_reset_a),  32'd1);
        chk("rst_mwr",   32'(mem_write_a),  32'd0);
        chk("rst_addr_a", 32'(mem_addr_a),  32'(BASE_A));
        chk("rst_addr_b", 32'(mem_addr_b),  32'(BASE_B));
        chk("rst_wdata", 32'(mem_wdata_a),  32'd0);
        chk("rst_done",  32'(boot_done_a),  32'd0);
        chk("rst_err",   32'(boot_error_a), 32'd0);
        chk("rst_rdy",   32'(rx_ready_a),   32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: three-byte image, strobes one cycle after each payload byte.
        stim_b.delete(); stim_g.delete();
        add(8'h5A, 0); add(8'h00, 0); add(8'h03, 0);
        add(8'h11, 0); add(8'h22, 0); add(8'h33, 0); add(8'h9A, 0);
        begin_frame();
        play(0, 4);
        chk("t1_wr0",   32'(mem_write_a), 32'd1);
        chk("t1_a0",    32'(mem_addr_a),  32'h0000);
        chk("t1_d0",    32'(mem_wdata_a), 32'h11);
        chk("t1_b0",    32'(mem_addr_b),  32'hFFFE);
        chk("t1_crst0", 32'(cpu_reset_a), 32'd1);
        play(4, 5);
        chk("t1_a1",    32'(mem_addr_a),  32'h0001);
        chk("t1_d1",    32'(mem_wdata_a), 32'h22);
        chk("t1_b1",    32'(mem_addr_b),  32'hFFFF);
        play(5, 6);
        chk("t1_a2",    32'(mem_addr_a),  32'h0002);
        chk("t1_b2",    32'(mem_addr_b),  32'h0000);
        play(6, 7);
        chk("t1_wr_end",  32'(mem_write_a), 32'd0);
        chk("t1_done_now", 32'(boot_done_a), 32'd1);
        chk("t1_crst_now", 32'(cpu_reset_a), 32'd0);
        chk("t1_rdy_now",  32'(rx_ready_a),  32'd0);
        settle_and_check("t1");

        // 2: leading garbage discarded.
        stim_b.delete(); stim_g.delete();
        add(8'h00, 0); add(8'hFF, 0); add(8'h5A, 0); add(8'h00, 0);
        add(8'h01, 0); add(8'hAA, 0); add(8'h56, 0);
        run_frame("t2");

        // 3: bad checksum, re-arm, then bytes without MAGIC stay in IDLE.
        stim_b.delete(); stim_g.delete();
        add(8'h5A, 0); add(8'h00, 0); add(8'h01, 0); add(8'hAA, 0); add(8'h00, 0);
        run_frame("t3");
        stim_b.delete(); stim_g.delete();
        add(8'h00, 0); add(8'h01, 0); add(8'hAA, 0); add(8'h56, 0);
        run_frame("t3_idle");

        // 4: oversize length rejected right after LEN_LO.
        stim_b.delete(); stim_g.delete();
        add(8'h5A, 0); add(8'h80, 0); add(8'h01, 0); add(8'h77, 0);
        begin_frame();
        play(0, 3);
        chk("t4_err_now", 32'(boot_error_a), 32'd1);
        play(3, 4);
        settle_and_check("t4");

        // 5: a 16-cycle stall times out, a 15-cycle stall does not.
        stim_b.delete(); stim_g.delete();
        add(8'h5A, 0); add(8'h00, 0); add(8'h03, 0); add(8'h10, 0);
        add(8'h20, 16); add(8'h30, 0); add(8'hA0, 0);
        run_frame("t5_16");
        stim_g[4] = 15;
        run_frame("t5_15");

        // 6: reset mid-payload returns everything to reset values at once.
        stim_b.delete(); stim_g.delete();
        add(8'h5A, 0); add(8'h00, 0); add(8'h05, 0); add(8'h01, 0); add(8'h02, 0);
        begin_frame();
        play(0, 5);
        chk("t6_pre_wr", 32'(mem_write_a), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_wr",     32'(mem_write_a),  32'd0);
        chk("t6_addr_a", 32'(mem_addr_a),   32'(BASE_A));
        chk("t6_addr_b", 32'(mem_addr_b),   32'(BASE_B));
        chk("t6_wdata",  32'(mem_wdata_b),  32'd0);
        chk("t6_crst",   32'(cpu_reset_a),  32'd1);
        chk("t6_err",    32'(boot_error_b), 32'd0);
        chk("t6_done",   32'(boot_done_b),  32'd0);
        chk("t6_rdy",    32'(rx_ready_b),   32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Random frames: garbage prefix, random lengths, gaps and checksums.
        for (int f = 0; f < 24; f++) begin
            int          ng;
            int          ln;
            int          np;
            logic [7:0]  s;
            logic [7:0]  b;
            stim_b.delete(); stim_g.delete();
            ng = int'($urandom_range(0, 2));
            for (int k = 0; k < ng; k++) begin
                b = 8'($urandom_range(0, 255));
                if (b == MAGIC) b = 8'h00;
                add(b, rgap());
            end
            add(MAGIC, rgap());
            case ($urandom_range(0, 7))
                0:       ln = 0;
                1:       ln = 32'h8001 + int'($urandom_range(0, 100));
                default: ln = int'($urandom_range(1, 6));
            endcase
            add(8'(ln >> 8), rgap());
            add(8'(ln), rgap());
            np = (ln > 8) ? 2 : ln;
            s = 8'h00;
            for (int k = 0; k < np; k++) begin
                b = 8'($urandom_range(0, 255));
                s = s + b;
                add(b, rgap());
            end
            if ($urandom_range(0, 3) == 0) add(8'h01 - s, rgap());
            else                           add(8'h00 - s, rgap());
            run_frame("rnd");
        end

        chk("no_write_released", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
